// File: rtl/chdr_flush_sequencer_if.sv
// Control/status bundle between a flush sequencer and the controller plus
// the CHDR data-to-packet channels it drives.
interface chdr_flush_sequencer_if #(
  parameter int NUM_PORTS = 4,
  parameter int TIMEOUT_W = 32,
  parameter int WAIT_W    = 16
);
  logic                 start;
  logic                 abort;
  logic [NUM_PORTS-1:0] port_mask;
  logic [TIMEOUT_W-1:0] timeout;
  logic [WAIT_W-1:0]    max_wait;
  logic [NUM_PORTS-1:0] flush_active;
  logic [NUM_PORTS-1:0] flush_done;
  logic                 flush_en;
  logic [TIMEOUT_W-1:0] flush_timeout;
  logic                 busy;
  logic                 done;
  logic                 err_timeout;
  logic                 err_drain;
  logic                 aborted;
  logic [NUM_PORTS-1:0] timed_out_mask;
  logic [7:0]           flush_cnt;

  modport master (
    input  start, abort, port_mask, timeout, max_wait, flush_active, flush_done,
    output flush_en, flush_timeout, busy, done, err_timeout, err_drain,
           aborted, timed_out_mask, flush_cnt
  );

  modport slave (
    output start, abort, port_mask, timeout, max_wait, flush_active, flush_done,
    input  flush_en, flush_timeout, busy, done, err_timeout, err_drain,
           aborted, timed_out_mask, flush_cnt
  );
endinterface

// File: rtl/chdr_flush_sequencer.sv
// Sequences a shared flush enable across CHDR channels: FLUSH until all masked
// channels report done, DRAIN until they go inactive, with watchdog and abort.
module chdr_flush_sequencer_core #(
  parameter int NUM_PORTS = 4,
  parameter int TIMEOUT_W = 32,
  parameter int WAIT_W    = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  chdr_flush_sequencer_if.master  bus
);
  typedef enum logic [1:0] {IDLE, FLUSH, DRAIN, DONE} state_t;

  state_t               state_q;
  logic [NUM_PORTS-1:0] mask_q;
  logic [NUM_PORTS-1:0] tmask_q;
  logic [TIMEOUT_W-1:0] timeout_q;
  logic [WAIT_W-1:0]    limit_q;
  logic [WAIT_W-1:0]    wd_q;
  logic                 flush_en_q, busy_q, done_q;
  logic                 err_to_q, err_dr_q, aborted_q;
  logic [7:0]           cnt_q;

  logic [WAIT_W-1:0]    wd_elapsed;
  logic                 wd_expired, all_done, drained;

  // wd_q counts completed cycles in the state; expiry compares the count
  // including the current cycle, so a limit of N allows exactly N cycles.
  assign wd_elapsed = (&wd_q) ? wd_q : wd_q + 1'b1;
  assign wd_expired = (limit_q != '0) && (wd_elapsed == limit_q);
  assign all_done   = ((bus.flush_done & mask_q) == mask_q);
  assign drained    = ((bus.flush_active & mask_q) == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      mask_q     <= '0;
      tmask_q    <= '0;
      timeout_q  <= '0;
      limit_q    <= '0;
      wd_q       <= '0;
      flush_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_to_q   <= 1'b0;
      err_dr_q   <= 1'b0;
      aborted_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            mask_q    <= bus.port_mask;
            timeout_q <= bus.timeout;
            limit_q   <= bus.max_wait;
            tmask_q   <= '0;
            err_to_q  <= 1'b0;
            err_dr_q  <= 1'b0;
            aborted_q <= 1'b0;
            wd_q      <= '0;
            busy_q    <= 1'b1;
            if (bus.port_mask == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              cnt_q   <= cnt_q + 1'b1;
            end else begin
              state_q    <= FLUSH;
              flush_en_q <= 1'b1;
            end
          end
        end
        FLUSH: begin
          wd_q <= wd_elapsed;
          if (bus.abort || all_done || wd_expired) begin
            state_q    <= DRAIN;
            flush_en_q <= 1'b0;
            wd_q       <= '0;
            if (bus.abort) begin
              aborted_q <= 1'b1;
            end else if (!all_done) begin
              err_to_q <= 1'b1;
              tmask_q  <= mask_q & ~bus.flush_done;
            end
          end
        end
        DRAIN: begin
          wd_q <= wd_elapsed;
          if (bus.abort || drained || wd_expired) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            if (bus.abort) aborted_q <= 1'b1;
            else if (!drained) err_dr_q <= 1'b1;
            if (!bus.abort && drained && !err_to_q && !aborted_q) cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.flush_en       = flush_en_q;
  assign bus.flush_timeout  = timeout_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.err_timeout    = err_to_q;
  assign bus.err_drain      = err_dr_q;
  assign bus.aborted        = aborted_q;
  assign bus.timed_out_mask = tmask_q;
  assign bus.flush_cnt      = cnt_q;
endmodule

module chdr_flush_sequencer #(
  parameter int NUM_PORTS = 4,
  parameter int TIMEOUT_W = 32,
  parameter int WAIT_W    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [NUM_PORTS-1:0] port_mask_i,
  input  logic [TIMEOUT_W-1:0] timeout_i,
  input  logic [WAIT_W-1:0]    max_wait_i,
  input  logic [NUM_PORTS-1:0] flush_active_i,
  input  logic [NUM_PORTS-1:0] flush_done_i,
  output logic                 flush_en_o,
  output logic [TIMEOUT_W-1:0] flush_timeout_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_timeout_o,
  output logic                 err_drain_o,
  output logic                 aborted_o,
  output logic [NUM_PORTS-1:0] timed_out_mask_o,
  output logic [7:0]           flush_cnt_o
);
  chdr_flush_sequencer_if #(
    .NUM_PORTS(NUM_PORTS), .TIMEOUT_W(TIMEOUT_W), .WAIT_W(WAIT_W)
  ) bus ();

  assign bus.start        = start_i;
  assign bus.abort        = abort_i;
  assign bus.port_mask    = port_mask_i;
  assign bus.timeout      = timeout_i;
  assign bus.max_wait     = max_wait_i;
  assign bus.flush_active = flush_active_i;
  assign bus.flush_done   = flush_done_i;

  assign flush_en_o       = bus.flush_en;
  assign flush_timeout_o  = bus.flush_timeout;
  assign busy_o           = bus.busy;
  assign done_o           = bus.done;
  assign err_timeout_o    = bus.err_timeout;
  assign err_drain_o      = bus.err_drain;
  assign aborted_o        = bus.aborted;
  assign timed_out_mask_o = bus.timed_out_mask;
  assign flush_cnt_o      = bus.flush_cnt;

  chdr_flush_sequencer_core #(
    .NUM_PORTS(NUM_PORTS), .TIMEOUT_W(TIMEOUT_W), .WAIT_W(WAIT_W)
  ) u_core (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.master)
  );
endmodule

// File: tb/tb_chdr_flush_sequencer.sv
// Scoreboard bench: each sequence plan is predicted at issue time and checked
// by an independent monitor when done_o pulses.
module tb_chdr_flush_sequencer;
  localparam int NP = 4;
  localparam int TW = 32;
  localparam int WW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  chdr_flush_sequencer_if #(.NUM_PORTS(NP), .TIMEOUT_W(TW), .WAIT_W(WW)) bus ();

  chdr_flush_sequencer #(.NUM_PORTS(NP), .TIMEOUT_W(TW), .WAIT_W(WW)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .start_i          (bus.start),
    .abort_i          (bus.abort),
    .port_mask_i      (bus.port_mask),
    .timeout_i        (bus.timeout),
    .max_wait_i       (bus.max_wait),
    .flush_active_i   (bus.flush_active),
    .flush_done_i     (bus.flush_done),
    .flush_en_o       (bus.flush_en),
    .flush_timeout_o  (bus.flush_timeout),
    .busy_o           (bus.busy),
    .done_o           (bus.done),
    .err_timeout_o    (bus.err_timeout),
    .err_drain_o      (bus.err_drain),
    .aborted_o        (bus.aborted),
    .timed_out_mask_o (bus.timed_out_mask),
    .flush_cnt_o      (bus.flush_cnt)
  );

  typedef struct {
    int unsigned f;
    int unsigned d;
    logic        et;
    logic        ed;
    logic        ab;
    logic [NP-1:0] tm;
    logic [7:0]  cnt;
    logic [TW-1:0] to;
  } exp_t;

  exp_t q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  // Current sequence plan (edge numbers count posedges after the start edge)
  logic [NP-1:0] p_mask;
  logic [TW-1:0] p_to;
  logic [WW-1:0] p_lim;
  int unsigned   p_done_at [NP];
  int unsigned   p_act_at, p_abort_f, p_abort_d;
  logic [7:0]    m_cnt = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp_v);
  endtask

  function automatic logic [NP-1:0] done_bits(input int unsigned e);
    logic [NP-1:0] r;
    for (int i = 0; i < NP; i++) r[i] = (p_done_at[i] != 0) && (e >= p_done_at[i]);
    return r;
  endfunction

  task automatic set_plan(input logic [NP-1:0] m, input logic [TW-1:0] to, input logic [WW-1:0] lim,
                          input int unsigned d0, input int unsigned d1, input int unsigned d2,
                          input int unsigned d3, input int unsigned act, input int unsigned af,
                          input int unsigned ad);
    p_mask = m; p_to = to; p_lim = lim;
    p_done_at[0] = d0; p_done_at[1] = d1; p_done_at[2] = d2; p_done_at[3] = d3;
    p_act_at = act; p_abort_f = af; p_abort_d = ad;
  endtask

  task automatic rand_plan();
    p_mask = NP'($urandom);
    p_to   = $urandom;
    p_lim  = ($urandom_range(0, 2) == 0) ? '0 : WW'($urandom_range(1, 12));
    for (int i = 0; i < NP; i++)
      p_done_at[i] = ($urandom_range(0, 3) == 0 && p_lim != 0) ? 0 : $urandom_range(1, 14);
    p_act_at  = ($urandom_range(0, 4) == 0 && p_lim != 0) ? 0 : $urandom_range(1, 25);
    p_abort_f = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 10) : 0;
    p_abort_d = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 6) : 0;
  endtask

  // Reference model: walk the plan edge by edge using the sequence rules.
  task automatic predict(output exp_t x, output bit ab_f, output bit ab_d);
    int unsigned e, j;
    bit fin;
    logic [NP-1:0] db;
    x.et = 0; x.ed = 0; x.ab = 0; x.tm = '0; x.to = p_to; x.f = 0; x.d = 0;
    ab_f = 0; ab_d = 0;
    if (p_mask != '0) begin
      e = 0; fin = 0;
      while (!fin && e < 4000) begin
        e++;
        db = done_bits(e) & p_mask;
        if (p_abort_f == e) begin x.ab = 1; ab_f = 1; fin = 1; end
        else if (db == p_mask) fin = 1;
        else if (p_lim != 0 && e == p_lim) begin x.et = 1; x.tm = p_mask & ~db; fin = 1; end
      end
      x.f = e;
      j = 0; fin = 0;
      while (!fin && j < 4000) begin
        j++;
        if (p_abort_d == j) begin x.ab = 1; ab_d = 1; fin = 1; end
        else if (p_act_at != 0 && x.f + j >= p_act_at) fin = 1;
        else if (p_lim != 0 && j == p_lim) begin x.ed = 1; fin = 1; end
      end
      x.d = j;
    end
    if (!x.et && !x.ed && !x.ab) m_cnt = m_cnt + 8'd1;
    x.cnt = m_cnt;
  endtask

  task automatic drive_ch(input int unsigned e);
    logic [NP-1:0] rd, ra;
    rd = NP'($urandom);
    ra = NP'($urandom);
    bus.flush_done   = (done_bits(e) & p_mask) | (rd & ~p_mask);
    bus.flush_active = ((p_act_at != 0 && e >= p_act_at) ? '0 : p_mask) | (ra & ~p_mask);
  endtask

  // Called positioned at a negedge; start is sampled at the following posedge.
  task automatic run_seq();
    exp_t x;
    bit ab_f, ab_d;
    int unsigned total;
    predict(x, ab_f, ab_d);
    q.push_back(x);
    total = x.f + x.d;
    bus.start = 1'b1; bus.abort = 1'b0;
    bus.port_mask = p_mask; bus.timeout = p_to; bus.max_wait = p_lim;
    drive_ch(0);
    @(negedge clk);
    for (int unsigned e = 1; e <= total; e++) begin
      bus.start     = ($urandom_range(0, 3) == 0);
      bus.port_mask = NP'($urandom);
      bus.timeout   = $urandom;
      bus.max_wait  = WW'($urandom);
      bus.abort     = (ab_f && e == x.f) || (ab_d && e == total);
      drive_ch(e);
      @(negedge clk);
    end
    bus.abort = 1'b0;
    bus.start = 1'($urandom);
    @(negedge clk);
    bus.start = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  int unsigned mon_en = 0;
  int unsigned mon_bz = 0;
  bit          mon_prev_done = 0;

  always @(negedge clk) begin : monitor
    exp_t x;
    if (rst) begin
      mon_en = 0; mon_bz = 0; mon_prev_done = 0;
    end else begin
      if (mon_prev_done) chk("after_done_idle", {30'd0, bus.busy, bus.done}, 32'd0);
      mon_prev_done = bus.done;
      if (bus.done) begin
        if (q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_done: done_o=1 with no outstanding sequence, want 0");
        end else begin
          x = q.pop_front();
          chk("flush_en_cycles", mon_en, x.f);
          chk("busy_cycles", mon_bz, x.f + x.d);
          chk("busy_in_done", {31'd0, bus.busy}, 32'd1);
          chk("err_timeout", {31'd0, bus.err_timeout}, {31'd0, x.et});
          chk("err_drain", {31'd0, bus.err_drain}, {31'd0, x.ed});
          chk("aborted", {31'd0, bus.aborted}, {31'd0, x.ab});
          chk("timed_out_mask", {28'd0, bus.timed_out_mask}, {28'd0, x.tm});
          chk("flush_cnt", {24'd0, bus.flush_cnt}, {24'd0, x.cnt});
          chk("flush_timeout", bus.flush_timeout, x.to);
        end
        mon_en = 0; mon_bz = 0;
      end else if (bus.busy) begin
        mon_bz++;
        if (bus.flush_en) mon_en++;
      end
    end
  end

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_flush_en"}, {31'd0, bus.flush_en}, 32'd0);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    chk({tag, "_errs"}, {29'd0, bus.err_timeout, bus.err_drain, bus.aborted}, 32'd0);
    chk({tag, "_tmask"}, {28'd0, bus.timed_out_mask}, 32'd0);
    chk({tag, "_cnt"}, {24'd0, bus.flush_cnt}, 32'd0);
    chk({tag, "_timeout"}, bus.flush_timeout, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.port_mask = '0; bus.timeout = '0;
    bus.max_wait = '0; bus.flush_active = '0; bus.flush_done = '0;
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b0;

    // normal, FLUSH watchdog, simultaneous done+expiry, abort vs all-done
    set_plan(4'b0101, 32'd1000, 16'd0, 6, 0, 6, 0, 8, 0, 0); run_seq();
    set_plan(4'b1111, 32'd77, 16'd8, 1, 1, 0, 0, 10, 0, 0); run_seq();
    set_plan(4'b1111, 32'd5, 16'd8, 8, 8, 8, 8, 9, 0, 0); run_seq();
    set_plan(4'b1111, 32'd9, 16'd0, 3, 3, 3, 3, 5, 3, 0); run_seq();
    // abort in DRAIN, DRAIN watchdog, zero mask
    set_plan(4'b0011, 32'd11, 16'd0, 2, 2, 0, 0, 0, 0, 3); run_seq();
    set_plan(4'b0010, 32'd12, 16'd4, 0, 2, 0, 0, 0, 0, 0); run_seq();
    set_plan(4'b0000, 32'hABCD, 16'd3, 0, 0, 0, 0, 0, 0, 0); run_seq();

    for (int i = 0; i < 60; i++) begin
      rand_plan();
      run_seq();
    end

    // enough clean zero-mask sequences to force a flush_cnt wrap
    for (int i = 0; i < 256; i++) begin
      set_plan(4'b0000, $urandom, 16'd0, 0, 0, 0, 0, 0, 0, 0);
      run_seq();
    end
    set_plan(4'b1001, 32'd3, 16'd0, 2, 0, 0, 4, 6, 0, 0); run_seq();

    // reset in the middle of FLUSH
    bus.start = 1'b1; bus.port_mask = 4'hF; bus.timeout = 32'h1234; bus.max_wait = '0;
    bus.flush_done = '0; bus.flush_active = '1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("pre_reset_flush_en", {31'd0, bus.flush_en}, 32'd1);
    #2 rst = 1'b1;
    #1 chk_idle_outputs("midreset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_cnt = 8'd0;
    set_plan(4'b0101, 32'd1000, 16'd0, 6, 0, 6, 0, 8, 0, 0); run_seq();

    repeat (4) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/chdr_flush_sequencer.md
CHDR_FLUSH_SEQUENCER -- requirements
Module: chdr_flush_sequencer

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4: number of CHDR data-to-packet channels sharing one flush enable.
REQ-002 SHALL have parameter TIMEOUT_W, default 32: width of the flush timeout forwarded to the channels.
REQ-003 SHALL have parameter WAIT_W, default 16: width of the watchdog counter and limit.
REQ-004 SHALL have ports in this order:
- clk_i  in  1  sole clock.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  request one flush sequence.
- abort_i  in  1  terminate the sequence in progress.
- port_mask_i  in  NUM_PORTS  channels that take part in the sequence.
- timeout_i  in  TIMEOUT_W  flush timeout value.
- max_wait_i  in  WAIT_W  watchdog limit in cycles; 0 disables the watchdog.
- flush_active_i  in  NUM_PORTS  per-channel flush-active status.
- flush_done_i  in  NUM_PORTS  per-channel flush-done status.
- flush_en_o  out  1  shared flush enable.
- flush_timeout_o  out  TIMEOUT_W  latched timeout.
- busy_o  out  1  a sequence is in progress.
- done_o  out  1  one-cycle end-of-sequence pulse.
- err_timeout_o  out  1  FLUSH state watchdog expired.
- err_drain_o  out  1  DRAIN state watchdog expired.
- aborted_o  out  1  sequence ended by abort_i.
- timed_out_mask_o  out  NUM_PORTS  channels that had not reached done when the watchdog expired.
- flush_cnt_o  out  8  count of error-free sequences.

Function
REQ-005 SHALL implement an FSM with states IDLE, FLUSH, DRAIN and DONE, and all outputs SHALL be registered.
REQ-006 In IDLE, start_i=1 SHALL cause the following at the next edge:
- latch port_mask_i, timeout_i and max_wait_i;
- clear err_timeout_o, err_drain_o, aborted_o and timed_out_mask_o;
- enter FLUSH, or enter DONE directly if port_mask_i is 0.
REQ-007 start_i outside IDLE SHALL be ignored, with no queuing.
REQ-008 flush_en_o SHALL be 1 exactly while in FLUSH, so it asserts one cycle after start_i is sampled.
REQ-009 flush_timeout_o SHALL hold the latched timeout and SHALL change only on an accepted start.
REQ-010 busy_o SHALL be 1 in FLUSH, DRAIN and DONE; done_o SHALL be 1 only in DONE, which lasts exactly one cycle and then returns to IDLE.
REQ-011 FLUSH SHALL go to DRAIN when (flush_done_i & mask) == mask is sampled.
REQ-012 The watchdog counter SHALL clear on entry to FLUSH and to DRAIN, increment each cycle in those states, and saturate at all-ones.
REQ-013 FLUSH watchdog expiry (limit != 0 and counter == limit, with not all masked done) SHALL:
- set err_timeout_o;
- set timed_out_mask_o = mask & ~flush_done_i;
- go to DRAIN.
REQ-014 If all-done and watchdog expiry are sampled in the same cycle, all-done SHALL win and no error SHALL be set.
REQ-015 DRAIN SHALL go to DONE when (flush_active_i & mask) == 0 is sampled.
REQ-016 DRAIN watchdog expiry SHALL set err_drain_o and go to DONE; simultaneous drain-complete SHALL win.
REQ-017 abort_i in FLUSH SHALL set aborted_o and go to DRAIN, and in DRAIN SHALL set aborted_o and go to DONE.
REQ-018 abort_i SHALL be ignored in IDLE and DONE, and abort_i SHALL take priority over all-done/drain-complete sampled in the same cycle.
REQ-019 Error flags SHALL be sticky until the next accepted start.
REQ-020 flush_cnt_o SHALL increment on entry to DONE only if no error flag or aborted_o is set, and SHALL wrap 255 -> 0.
REQ-021 A zero-mask sequence SHALL increment flush_cnt_o.
REQ-022 flush_*_i bits outside the latched mask SHALL be ignored.

Reset
REQ-023 rst_i=1 SHALL immediately force:
- state to IDLE;
- flush_en_o, busy_o, done_o and all error flags to 0;
- timed_out_mask_o, flush_timeout_o, flush_cnt_o and the latched mask/limits to 0.
This SHALL apply even mid-sequence, with no completion pulse.
REQ-024 After rst_i deasserts, the first start_i SHALL be accepted at the first rising edge.

Verification
REQ-025 The bench SHALL cover these scenarios:
- Normal sequence: mask=4'b0101, timeout=1000, max_wait=0; done[0],[2] rise after 5 cycles; active falls 2 cycles later -> flush_en high 1 cycle after start for 6 cycles, done_o pulse, flush_cnt 0 -> 1, no errors.
- FLUSH watchdog: mask=4'b1111, max_wait=8, only done[1:0] high -> err_timeout_o=1, timed_out_mask_o=4'b1100, flush_en low after 8 FLUSH cycles, flush_cnt unchanged.
- Simultaneous events: all done at the watchdog-expiry cycle -> no error; abort_i with all done in FLUSH -> aborted_o=1.
- Boundaries: zero mask -> done_o 1 cycle after start, flush_en never high; flush_cnt 255 -> 0 wrap; start_i while busy ignored.
- Mid-sequence reset: rst_i during FLUSH -> flush_en_o and busy_o low immediately, flush_cnt_o=0; a following start behaves normally.
